filter_frame_ctrl: RTL

//  Frame sequencer in front of filter_mod (sharpening filter, RGB stream).
//  - Accepts pixels from a valid/ready source and drives the filter input strobe (data_in_done).
//  - After the last pixel of a frame, feeds flush pixels so the filter line buffers drain.
//  - Gates the filter output stream to exactly ROWS*COLS pixels and reports frame completion.

---
 rtl/filter_frame_ctrl_if.sv | 40 ++++
 rtl/filter_frame_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/filter_frame_ctrl_if.sv
// Pixel stream bundle around filter_frame_ctrl: source in, filter in/out, gated dst out.
// master is the controller side, slave is the surrounding datapath.
interface filter_frame_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             src_valid;
    logic             src_ready;
    logic [WIDTH-1:0] src_r;
    logic [WIDTH-1:0] src_g;
    logic [WIDTH-1:0] src_b;
    logic             filt_reset;
    logic [WIDTH-1:0] filt_r;
    logic [WIDTH-1:0] filt_g;
    logic [WIDTH-1:0] filt_b;
    logic             filt_in_done;
    logic [WIDTH-1:0] filt_r_o;
    logic [WIDTH-1:0] filt_g_o;
    logic [WIDTH-1:0] filt_b_o;
    logic             filt_out_done;
    logic [WIDTH-1:0] dst_r;
    logic [WIDTH-1:0] dst_g;
    logic [WIDTH-1:0] dst_b;
    logic             dst_valid;

    modport master (
        input  src_valid, src_r, src_g, src_b,
        input  filt_r_o, filt_g_o, filt_b_o, filt_out_done,
        output src_ready, filt_reset,
        output filt_r, filt_g, filt_b, filt_in_done,
        output dst_r, dst_g, dst_b, dst_valid
    );

    modport slave (
        output src_valid, src_r, src_g, src_b,
        output filt_r_o, filt_g_o, filt_b_o, filt_out_done,
        input  src_ready, filt_reset,
        input  filt_r, filt_g, filt_b, filt_in_done,
        input  dst_r, dst_g, dst_b, dst_valid
    );
endinterface

// File: rtl/filter_frame_ctrl.sv
// Frame sequencer for the sharpening filter: feeds a frame, flushes the line
// buffers with zero pixels, then gates exactly ROWS*COLS output pixels.
module filter_frame_ctrl #(
    parameter int WIDTH     = 8,
    parameter int ROWS      = 512,
    parameter int COLS      = 512,
    parameter int LINE_BITS = 10,
    parameter int FLUSH_PIX = 1026,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    filter_frame_ctrl_if.master  bus,
    output logic [LINE_BITS-1:0] row_idx,
    output logic [LINE_BITS-1:0] col_idx,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 timeout_err
);
    localparam int CW = 2 * LINE_BITS + 1;
    localparam int FW = $clog2(FLUSH_PIX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TOTAL = CW'(ROWS * COLS);

    typedef enum logic [2:0] {
        S_IDLE, S_FEED, S_FLUSH, S_DRAIN, S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [LINE_BITS-1:0] row_q, row_d, col_q, col_d;
    logic [CW-1:0]        out_cnt_q, out_cnt_d;
    logic [FW-1:0]        flush_cnt_q, flush_cnt_d;
    logic [TW-1:0]        idle_cnt_q, idle_cnt_d;
    logic [3*WIDTH-1:0]   filt_px_q, filt_px_d;
    logic                 filt_in_done_q, filt_in_done_d;
    logic [3*WIDTH-1:0]   dst_px_q, dst_px_d;
    logic                 dst_valid_q, dst_valid_d;
    logic                 terr_q, terr_d;

    logic src_ready, accept, launch, active, take;

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        col_d          = col_q;
        out_cnt_d      = out_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        idle_cnt_d     = '0;
        filt_px_d      = filt_px_q;
        filt_in_done_d = 1'b0;
        dst_px_d       = dst_px_q;
        dst_valid_d    = 1'b0;
        terr_d         = terr_q;

        src_ready = (state_q == S_FEED) && !abort;
        accept    = bus.src_valid && src_ready;
        launch    = (state_q == S_IDLE) && start && !abort;
        active    = (state_q == S_FEED) || (state_q == S_FLUSH)
                 || (state_q == S_DRAIN);
        take      = active && !abort && bus.filt_out_done
                 && (out_cnt_q < TOTAL);

        if (take) begin
            dst_px_d    = {bus.filt_r_o, bus.filt_g_o, bus.filt_b_o};
            dst_valid_d = 1'b1;
            out_cnt_d   = out_cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d     = S_FEED;
                    row_d       = '0;
                    col_d       = '0;
                    out_cnt_d   = '0;
                    flush_cnt_d = '0;
                    terr_d      = 1'b0;
                end
            end
            S_FEED: begin
                if (accept) begin
                    filt_px_d      = {bus.src_r, bus.src_g, bus.src_b};
                    filt_in_done_d = 1'b1;
                    if (col_q == LINE_BITS'(COLS - 1)) begin
                        col_d = '0;
                        if (row_q == LINE_BITS'(ROWS - 1)) begin
                            row_d       = '0;
                            flush_cnt_d = '0;
                            state_d     = S_FLUSH;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                filt_px_d      = '0;
                filt_in_done_d = 1'b1;
                flush_cnt_d    = flush_cnt_q + 1'b1;
                if (flush_cnt_q == FW'(FLUSH_PIX - 1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_cnt_q == TOTAL) begin
                    state_d = S_DONE;
                end else begin
                    // Silence counter restarts on every filter output pulse
                    idle_cnt_d = bus.filt_out_done ? '0 : idle_cnt_q + 1'b1;
                    if (idle_cnt_d == TW'(TIMEOUT)) begin
                        terr_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d        = S_IDLE;
            filt_in_done_d = 1'b0;
            dst_valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            row_q          <= '0;
            col_q          <= '0;
            out_cnt_q      <= '0;
            flush_cnt_q    <= '0;
            idle_cnt_q     <= '0;
            filt_px_q      <= '0;
            filt_in_done_q <= 1'b0;
            dst_px_q       <= '0;
            dst_valid_q    <= 1'b0;
            terr_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            col_q          <= col_d;
            out_cnt_q      <= out_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            idle_cnt_q     <= idle_cnt_d;
            filt_px_q      <= filt_px_d;
            filt_in_done_q <= filt_in_done_d;
            dst_px_q       <= dst_px_d;
            dst_valid_q    <= dst_valid_d;
            terr_q         <= terr_d;
        end
    end

    assign bus.src_ready    = src_ready;
    assign bus.filt_reset   = launch;
    assign bus.filt_r       = filt_px_q[3*WIDTH-1:2*WIDTH];
    assign bus.filt_g       = filt_px_q[2*WIDTH-1:WIDTH];
    assign bus.filt_b       = filt_px_q[WIDTH-1:0];
    assign bus.filt_in_done = filt_in_done_q;
    assign bus.dst_r        = dst_px_q[3*WIDTH-1:2*WIDTH];
    assign bus.dst_g        = dst_px_q[2*WIDTH-1:WIDTH];
    assign bus.dst_b        = dst_px_q[WIDTH-1:0];
    assign bus.dst_valid    = dst_valid_q;
    assign row_idx          = row_q;
    assign col_idx          = col_q;
    assign busy             = (state_q != S_IDLE);
    assign frame_done       = (state_q == S_DONE);
    assign timeout_err      = terr_q;
endmodule
